// File: rtl/config_chain_reg.sv
// Configuration shift-register cell for the fabric config chain.
//
// Shifts LANES bits per beat into a shadow register while config_en is high.
// When config_en drops, the shadow is committed to the active bits, optionally
// only if exactly WORDS beats were shifted. config_capture (idle only) copies
// the active bits back into the shadow, so the next frame shifts them out.
//
// Ports:
//   config_clk     - sole clock, rising edge
//   sys_reset      - synchronous active-high reset
//   config_in      - LANES-bit serial data in, sampled while config_en = 1
//   config_en      - frame enable; falling edge ends the frame
//   config_capture - readback request: load config_bits into the shadow
//   config_out     - top LANES bits of the shadow, feeds the next cell
//   config_bits    - active configuration
//   config_done    - one-cycle pulse on successful commit
//   config_err     - sticky length-error flag, cleared at frame start
//   config_valid   - set once any commit has succeeded since reset
//   config_count   - beats shifted in the current/last frame, saturates at WORDS+1
module config_chain_reg #(
    parameter int unsigned CONFIG_WIDTH = 65,
    parameter int unsigned LANES        = 1,
    parameter int unsigned CHECK_LEN    = 1,
    localparam int unsigned WORDS       = CONFIG_WIDTH / LANES,
    localparam int unsigned CW          = $clog2(WORDS + 2)
) (
    input  logic                    config_clk,
    input  logic                    sys_reset,
    input  logic [LANES-1:0]        config_in,
    input  logic                    config_en,
    input  logic                    config_capture,
    output logic [LANES-1:0]        config_out,
    output logic [CONFIG_WIDTH-1:0] config_bits,
    output logic                    config_done,
    output logic                    config_err,
    output logic                    config_valid,
    output logic [CW-1:0]           config_count
);

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    localparam logic [CW-1:0] COUNT_MAX  = CW'(WORDS + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(WORDS);

    logic                    state_q, state_d;
    logic                    en_d;
    logic [CONFIG_WIDTH-1:0] shift_q, shift_d;
    logic [CONFIG_WIDTH-1:0] mem_q, mem_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    valid_q, valid_d;

    logic [CONFIG_WIDTH-1:0] shifted;
    logic                    frame_end;
    logic                    len_ok;

    // New lanes enter at the bottom; config_in[LANES-1] is the oldest lane.
    if (LANES == CONFIG_WIDTH) begin : g_full
        assign shifted = config_in;
    end else begin : g_part
        assign shifted = {shift_q[CONFIG_WIDTH-LANES-1:0], config_in};
    end

    assign frame_end = en_d & ~config_en;
    assign len_ok    = (CHECK_LEN == 0) || (count_q == COUNT_FULL);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        mem_d   = mem_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (config_en) begin
                    // Frame start: shift wins over a simultaneous capture.
                    state_d = SHIFT;
                    shift_d = shifted;
                    count_d = CW'(1);
                    err_d   = 1'b0;
                end else if (config_capture) begin
                    shift_d = mem_q;
                end
            end
            SHIFT: begin
                if (config_en) begin
                    shift_d = shifted;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + CW'(1);
                    end
                end else if (frame_end) begin
                    state_d = IDLE;
                    if (len_ok) begin
                        mem_d   = shift_q;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge config_clk) begin
        if (sys_reset) begin
            state_q <= IDLE;
            en_d    <= 1'b0;
            shift_q <= '0;
            mem_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_d    <= config_en;
            shift_q <= shift_d;
            mem_q   <= mem_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign config_out   = shift_q[CONFIG_WIDTH-1 -: LANES];
    assign config_bits  = mem_q;
    assign config_done  = done_q;
    assign config_err   = err_q;
    assign config_valid = valid_q;
    assign config_count = count_q;

endmodule

// File: tb/tb_config_chain_reg.sv
// Bench for config_chain_reg: three instances (8x2 checked, 8x2 unchecked,
// 1x1 checked) driven frame by frame from a vector table.
module tb_config_chain_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en  [3];
    logic [1:0] din [3];
    logic       cap [3];

    logic [1:0] out_a, out_b;
    logic [7:0] bits_a, bits_b;
    logic       done_a, done_b, err_a, err_b, valid_a, valid_b;
    logic [2:0] count_a, count_b;
    logic [0:0] out_c, bits_c;
    logic       done_c, err_c, valid_c;
    logic [1:0] count_c;

    config_chain_reg #(.CONFIG_WIDTH(8), .LANES(2), .CHECK_LEN(1)) dut_a (
        .config_clk(clk), .sys_reset(rst), .config_in(din[0]), .config_en(en[0]),
        .config_capture(cap[0]), .config_out(out_a), .config_bits(bits_a),
        .config_done(done_a), .config_err(err_a), .config_valid(valid_a),
        .config_count(count_a)
    );

    config_chain_reg #(.CONFIG_WIDTH(8), .LANES(2), .CHECK_LEN(0)) dut_b (
        .config_clk(clk), .sys_reset(rst), .config_in(din[1]), .config_en(en[1]),
        .config_capture(cap[1]), .config_out(out_b), .config_bits(bits_b),
        .config_done(done_b), .config_err(err_b), .config_valid(valid_b),
        .config_count(count_b)
    );

    config_chain_reg #(.CONFIG_WIDTH(1), .LANES(1), .CHECK_LEN(1)) dut_c (
        .config_clk(clk), .sys_reset(rst), .config_in(din[2][0]), .config_en(en[2]),
        .config_capture(cap[2]), .config_out(out_c), .config_bits(bits_c),
        .config_done(done_c), .config_err(err_c), .config_valid(valid_c),
        .config_count(count_c)
    );

    typedef struct {
        logic [7:0] bits;
        logic       done;
        logic       err;
        logic       valid;
        logic [2:0] cnt;
    } exp_t;

    // beats/outs hold the first entry in the top two bits.
    typedef struct {
        int          dut;
        int          n;
        logic        do_cap;
        logic [15:0] beats;
        logic        chk;
        logic [17:0] outs;
        logic [7:0]  bits;
        logic        done;
        logic        err;
        logic        valid;
        logic [2:0]  cnt;
    } vec_t;

    typedef struct {
        logic [1:0] out;
        logic [7:0] bits;
        logic       done;
        logic       err;
        logic       valid;
        logic [2:0] cnt;
    } obs_t;

    vec_t tbl [12];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int d, output obs_t o);
        case (d)
            0: begin
                o.out = out_a; o.bits = bits_a; o.done = done_a;
                o.err = err_a; o.valid = valid_a; o.cnt = count_a;
            end
            1: begin
                o.out = out_b; o.bits = bits_b; o.done = done_b;
                o.err = err_b; o.valid = valid_b; o.cnt = count_b;
            end
            default: begin
                o.out = {1'b0, out_c}; o.bits = {7'b0, bits_c}; o.done = done_c;
                o.err = err_c; o.valid = valid_c; o.cnt = {1'b0, count_c};
            end
        endcase
    endtask

    task automatic check_zero(input int d, input string tag);
        obs_t o;
        sample(d, o);
        check($sformatf("%s d%0d out", tag, d), o.out, 0);
        check($sformatf("%s d%0d bits", tag, d), o.bits, 0);
        check($sformatf("%s d%0d done", tag, d), o.done, 0);
        check($sformatf("%s d%0d err", tag, d), o.err, 0);
        check($sformatf("%s d%0d valid", tag, d), o.valid, 0);
        check($sformatf("%s d%0d count", tag, d), o.cnt, 0);
    endtask

    task automatic run(input int idx, input vec_t v);
        obs_t o;
        exp_t e;
        int   d;
        d = v.dut;
        sb.push_back('{bits: v.bits, done: v.done, err: v.err, valid: v.valid, cnt: v.cnt});
        if (v.do_cap) begin
            @(negedge clk); cap[d] = 1'b1;
            @(negedge clk); cap[d] = 1'b0;
        end
        for (int i = 0; i <= v.n; i++) begin
            @(negedge clk);
            sample(d, o);
            if (v.chk) check($sformatf("v%0d out[%0d]", idx, i), o.out, v.outs[17-2*i -: 2]);
            if (i == 1) begin
                check($sformatf("v%0d err at start", idx), o.err, 0);
                check($sformatf("v%0d done at start", idx), o.done, 0);
                check($sformatf("v%0d count at start", idx), o.cnt, 1);
            end
            if (i < v.n) begin
                en[d]  = 1'b1;
                din[d] = v.beats[15-2*i -: 2];
            end else begin
                en[d]  = 1'b0;
                din[d] = 2'b00;
            end
        end
        @(negedge clk);
        sample(d, o);
        e = sb.pop_front();
        check($sformatf("v%0d bits", idx), o.bits, e.bits);
        check($sformatf("v%0d done", idx), o.done, e.done);
        check($sformatf("v%0d err", idx), o.err, e.err);
        check($sformatf("v%0d valid", idx), o.valid, e.valid);
        check($sformatf("v%0d count", idx), o.cnt, e.cnt);
        @(negedge clk);
        sample(d, o);
        check($sformatf("v%0d done after", idx), o.done, 0);
        check($sformatf("v%0d bits after", idx), o.bits, e.bits);
    endtask

    initial begin
        // 8x2 checked
        tbl[0]  = '{dut: 0, n: 4, do_cap: 0, beats: 16'hB100, chk: 0, outs: 18'h0,
                    bits: 8'hB1, done: 1, err: 0, valid: 1, cnt: 4};
        tbl[1]  = '{dut: 0, n: 3, do_cap: 0, beats: 16'hFC00, chk: 0, outs: 18'h0,
                    bits: 8'hB1, done: 0, err: 1, valid: 1, cnt: 3};
        tbl[2]  = '{dut: 0, n: 4, do_cap: 0, beats: 16'h5A00, chk: 0, outs: 18'h0,
                    bits: 8'h5A, done: 1, err: 0, valid: 1, cnt: 4};
        tbl[3]  = '{dut: 0, n: 6, do_cap: 0, beats: 16'hF390, chk: 0, outs: 18'h0,
                    bits: 8'h5A, done: 0, err: 1, valid: 1, cnt: 5};
        // 8x2 unchecked: last four beats 00,11,10,01 commit
        tbl[4]  = '{dut: 1, n: 6, do_cap: 0, beats: 16'hF390, chk: 0, outs: 18'h0,
                    bits: 8'h39, done: 1, err: 0, valid: 1, cnt: 5};
        // 1x1 checked
        tbl[5]  = '{dut: 2, n: 1, do_cap: 0, beats: 16'h4000, chk: 1,
                    outs: 18'b00_01_00_00_00_00_00_00_00,
                    bits: 8'h01, done: 1, err: 0, valid: 1, cnt: 1};
        tbl[6]  = '{dut: 2, n: 2, do_cap: 0, beats: 16'h1000, chk: 0, outs: 18'h0,
                    bits: 8'h01, done: 0, err: 1, valid: 1, cnt: 2};
        // Readback: commit B1, dirty the shadow with a short frame, capture, shift out
        tbl[7]  = '{dut: 0, n: 4, do_cap: 0, beats: 16'hB100, chk: 0, outs: 18'h0,
                    bits: 8'hB1, done: 1, err: 0, valid: 1, cnt: 4};
        tbl[8]  = '{dut: 0, n: 3, do_cap: 0, beats: 16'h0000, chk: 0, outs: 18'h0,
                    bits: 8'hB1, done: 0, err: 1, valid: 1, cnt: 3};
        tbl[9]  = '{dut: 0, n: 4, do_cap: 1, beats: 16'h0000, chk: 1,
                    outs: 18'b10_11_00_01_00_00_00_00_00,
                    bits: 8'h00, done: 1, err: 0, valid: 1, cnt: 4};
        tbl[10] = '{dut: 0, n: 4, do_cap: 0, beats: 16'h5A00, chk: 0, outs: 18'h0,
                    bits: 8'h5A, done: 1, err: 0, valid: 1, cnt: 4};
        // After mid-frame reset
        tbl[11] = '{dut: 0, n: 4, do_cap: 0, beats: 16'hB100, chk: 0, outs: 18'h0,
                    bits: 8'hB1, done: 1, err: 0, valid: 1, cnt: 4};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b0; din[d] = 2'b00; cap[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) check_zero(d, "reset");
        rst = 1'b0;

        for (int k = 0; k < 11; k++) run(k, tbl[k]);

        // Reset asserted on beat 2 of a frame after a prior commit.
        @(negedge clk); en[0] = 1'b1; din[0] = 2'b11;
        @(negedge clk); din[0] = 2'b00; rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_zero(d, "midreset");
        rst = 1'b0; en[0] = 1'b0;

        run(11, tbl[11]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
